// File: rtl/cv32e40p_ft_vote_monitor.sv
// TMR vote-and-monitor: votes three replica bundles, attributes mismatches,
// tracks per-replica health, retires faulty replicas and re-admits them after a clean window.

module cv32e40p_ft_vote_monitor_voter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [2:0]       i_adm,
  output logic [WIDTH-1:0] o_voted_c,
  output logic [2:0]       o_blk_err_c,
  output logic             o_err_det_c,
  output logic             o_err_corr_c
);

  logic [WIDTH-1:0] w_maj;

  assign w_maj = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

  // Vote according to the admitted set; a disagreeing pair falls back to its lower index
  always_comb begin
    o_voted_c    = i_a;
    o_blk_err_c  = 3'b000;
    o_err_det_c  = 1'b0;
    o_err_corr_c = 1'b0;
    case (i_adm)
      3'b111: begin
        o_voted_c    = w_maj;
        o_blk_err_c  = {i_c != w_maj, i_b != w_maj, i_a != w_maj};
        o_err_det_c  = |o_blk_err_c;
        o_err_corr_c = o_err_det_c;
      end
      3'b011: begin
        o_voted_c = i_a;
        if (i_a != i_b) begin
          o_blk_err_c = 3'b011;
          o_err_det_c = 1'b1;
        end
      end
      3'b101: begin
        o_voted_c = i_a;
        if (i_a != i_c) begin
          o_blk_err_c = 3'b101;
          o_err_det_c = 1'b1;
        end
      end
      3'b110: begin
        o_voted_c = i_b;
        if (i_b != i_c) begin
          o_blk_err_c = 3'b110;
          o_err_det_c = 1'b1;
        end
      end
      3'b001:  o_voted_c = i_a;
      3'b010:  o_voted_c = i_b;
      3'b100:  o_voted_c = i_c;
      default: o_voted_c = i_a;
    endcase
  end

endmodule

module cv32e40p_ft_vote_monitor #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TOUT           = 0,
  parameter int unsigned INCREMENT      = 4,
  parameter int unsigned DECREMENT      = 1,
  parameter int unsigned THRESHOLD      = 12,
  parameter int unsigned COUNT_BIT      = 4,
  parameter int unsigned RECOVER_EN     = 1,
  parameter int unsigned RECOVER_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3*WIDTH-1:0]     to_vote_i,
  input  logic [2:0]             set_broken_i,
  output logic [3*WIDTH-1:0]     voted_o,
  output logic [2:0]             is_broken_o,
  output logic                   err_detected_o,
  output logic                   err_corrected_o,
  output logic                   all_broken_o,
  output logic [3*COUNT_BIT-1:0] health_o
);

  localparam int unsigned CLEAN_W   = $clog2(RECOVER_CYCLES + 1);
  localparam int unsigned HEALTH_MX = (1 << COUNT_BIT) - 1;

  logic [COUNT_BIT-1:0] r_health [3];
  logic [CLEAN_W-1:0]   r_clean  [3];
  logic [2:0]           r_broken;
  logic [2:0]           r_forced;
  logic                 r_all_broken;

  logic [COUNT_BIT-1:0] w_health_nxt [3];
  logic [CLEAN_W-1:0]   w_clean_nxt  [3];
  logic [CLEAN_W-1:0]   w_clean_inc  [3];
  logic [2:0]           w_broken_nxt;
  logic [2:0]           w_forced_nxt;
  logic                 w_readmitted;

  logic [2:0]           w_adm;
  logic [WIDTH-1:0]     w_lane [3];
  logic [2:0]           w_blk_err;
  logic                 w_err_det;
  logic                 w_err_corr;

  // Reset admits every lane so the output is the plain majority while rst_n is low
  assign w_adm = rst_n ? ~r_broken : 3'b111;

  for (genvar k = 0; k < 3; k++) begin : g_lane
    assign w_lane[k] = to_vote_i[k*WIDTH +: WIDTH];
    assign health_o[k*COUNT_BIT +: COUNT_BIT] = r_health[k];
  end

  if (TOUT != 0) begin : g_tout
    logic [WIDTH-1:0] w_v   [3];
    logic [2:0]       w_blk [3];
    logic [2:0]       w_det;
    logic [2:0]       w_corr;

    for (genvar j = 0; j < 3; j++) begin : g_voter
      cv32e40p_ft_vote_monitor_voter #(.WIDTH(WIDTH)) u_voter (
        .i_a          (w_lane[0]),
        .i_b          (w_lane[1]),
        .i_c          (w_lane[2]),
        .i_adm        (w_adm),
        .o_voted_c    (w_v[j]),
        .o_blk_err_c  (w_blk[j]),
        .o_err_det_c  (w_det[j]),
        .o_err_corr_c (w_corr[j])
      );
      assign voted_o[j*WIDTH +: WIDTH] = w_v[j];
    end

    // Status from the three copies is itself majority-voted
    assign w_blk_err  = (w_blk[0] & w_blk[1]) | (w_blk[0] & w_blk[2]) | (w_blk[1] & w_blk[2]);
    assign w_err_det  = (w_det[0] & w_det[1]) | (w_det[0] & w_det[2]) | (w_det[1] & w_det[2]);
    assign w_err_corr = (w_corr[0] & w_corr[1]) | (w_corr[0] & w_corr[2]) | (w_corr[1] & w_corr[2]);
  end else begin : g_single
    logic [WIDTH-1:0] w_v;

    cv32e40p_ft_vote_monitor_voter #(.WIDTH(WIDTH)) u_voter (
      .i_a          (w_lane[0]),
      .i_b          (w_lane[1]),
      .i_c          (w_lane[2]),
      .i_adm        (w_adm),
      .o_voted_c    (w_v),
      .o_blk_err_c  (w_blk_err),
      .o_err_det_c  (w_err_det),
      .o_err_corr_c (w_err_corr)
    );
    assign voted_o = {3{w_v}};
  end

  assign err_detected_o  = w_err_det;
  assign err_corrected_o = w_err_corr;
  assign is_broken_o     = r_broken;
  assign all_broken_o    = r_all_broken;

  function automatic logic [COUNT_BIT-1:0] f_health_upd(input logic [COUNT_BIT-1:0] i_cnt,
                                                         input logic             i_err);
    logic [32:0] w_cnt;
    w_cnt = 33'(i_cnt);
    if (i_err) begin
      w_cnt = w_cnt + 33'(INCREMENT);
      if (w_cnt > 33'(HEALTH_MX)) w_cnt = 33'(HEALTH_MX);
    end else if (w_cnt > 33'(DECREMENT)) begin
      w_cnt = w_cnt - 33'(DECREMENT);
    end else begin
      w_cnt = 33'd0;
    end
    return COUNT_BIT'(w_cnt);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_inc
    assign w_clean_inc[k] = (r_clean[k] >= CLEAN_W'(RECOVER_CYCLES)) ?
                            CLEAN_W'(RECOVER_CYCLES) : r_clean[k] + CLEAN_W'(1);
  end

  // Next-state for health, retirement, forced flag and recovery window
  always_comb begin
    w_health_nxt = r_health;
    w_clean_nxt  = r_clean;
    w_broken_nxt = r_broken;
    w_forced_nxt = r_forced | set_broken_i;
    w_readmitted = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!r_broken[k]) begin
        w_health_nxt[k] = f_health_upd(r_health[k], w_blk_err[k]);
        w_clean_nxt[k]  = '0;
        if (33'(w_health_nxt[k]) >= 33'(THRESHOLD)) w_broken_nxt[k] = 1'b1;
      end else if ((RECOVER_EN != 0) && !r_forced[k] && (r_broken != 3'b111)) begin
        if (w_lane[k] != voted_o[WIDTH-1:0]) begin
          w_clean_nxt[k] = '0;
        end else if ((w_clean_inc[k] == CLEAN_W'(RECOVER_CYCLES)) && !set_broken_i[k]
                     && !w_readmitted) begin
          w_broken_nxt[k] = 1'b0;
          w_health_nxt[k] = '0;
          w_clean_nxt[k]  = '0;
          w_readmitted    = 1'b1;
        end else begin
          w_clean_nxt[k] = w_clean_inc[k];
        end
      end
      if (set_broken_i[k]) w_broken_nxt[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        r_health[k] <= '0;
        r_clean[k]  <= '0;
      end
      r_broken     <= 3'b000;
      r_forced     <= 3'b000;
      r_all_broken <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        r_health[k] <= w_health_nxt[k];
        r_clean[k]  <= w_clean_nxt[k];
      end
      r_broken     <= w_broken_nxt;
      r_forced     <= w_forced_nxt;
      r_all_broken <= &w_broken_nxt;
    end
  end

endmodule

// File: tb/tb_cv32e40p_ft_vote_monitor.sv
// Directed bench for the TMR vote-and-monitor: voting, health, retirement, recovery, reset.

module tb_cv32e40p_ft_vote_monitor;

  logic        clk;
  logic        rst_n;
  logic [95:0] to_vote;
  logic [2:0]  set_broken;

  logic [95:0] voted0, voted1;
  logic [2:0]  broken0, broken1;
  logic        det0, det1, corr0, corr1, allb0, allb1;
  logic [11:0] health0, health1;

  int n_checks = 0;
  int n_pass   = 0;

  cv32e40p_ft_vote_monitor #(.WIDTH(32), .TOUT(0)) dut0 (
    .clk             (clk),
    .rst_n           (rst_n),
    .to_vote_i       (to_vote),
    .set_broken_i    (set_broken),
    .voted_o         (voted0),
    .is_broken_o     (broken0),
    .err_detected_o  (det0),
    .err_corrected_o (corr0),
    .all_broken_o    (allb0),
    .health_o        (health0)
  );

  cv32e40p_ft_vote_monitor #(.WIDTH(32), .TOUT(1)) dut1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .to_vote_i       (to_vote),
    .set_broken_i    (set_broken),
    .voted_o         (voted1),
    .is_broken_o     (broken1),
    .err_detected_o  (det1),
    .err_corrected_o (corr1),
    .all_broken_o    (allb1),
    .health_o        (health1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    to_vote = {c, b, a};
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    set_broken = 3'b000;
    drive(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);

    // Reset
    @(negedge clk);
    check("rst_vote", voted0, {3{32'hDEADBEEF}});
    tick();
    rst_n = 1'b1;
    check("rst_broken", 96'(broken0), 96'(3'b000));
    check("rst_allb", 96'(allb0), 96'(1'b0));
    check("rst_health", 96'(health0), 96'(12'h000));

    // Fault-free
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("clean_vote", voted0, {3{32'hDEADBEEF}});
      check("clean_err", 96'({det0, corr0}), 96'(2'b00));
      tick();
      check("clean_health", 96'(health0), 96'(12'h000));
    end

    // Lane 1 single-bit fault until retired
    drive(32'hDEADBEEF, 32'hDEADBEEE, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fault_vote", voted0, {3{32'hDEADBEEF}});
      check("fault_err", 96'({det0, corr0}), 96'(2'b11));
      tick();
      check("fault_health", 96'(health0), 96'({4'h0, 4'(4 * (i + 1)), 4'h0}));
      check("fault_broken", 96'(broken0), (i == 2) ? 96'(3'b010) : 96'(3'b000));
    end
    @(negedge clk);
    check("retired_err", 96'({det0, corr0}), 96'(2'b00));
    check("retired_vote", voted0, {3{32'hDEADBEEF}});
    tick();
    check("retired_health", 96'(health0), 96'(12'h0C0));

    // Two admitted lanes disagree
    drive(32'h1, 32'h3, 32'h2);
    @(negedge clk);
    check("pair_vote", voted0, {3{32'h1}});
    check("pair_err", 96'({det0, corr0}), 96'(2'b10));
    tick();
    check("pair_health", 96'(health0), 96'(12'h4C4));
    check("pair_broken", 96'(broken0), 96'(3'b010));

    // Recovery: 63 clean, one mismatch, then 64 clean
    drive(32'h55, 32'h55, 32'h55);
    repeat (63) tick();
    check("rec63_broken", 96'(broken0), 96'(3'b010));
    check("rec63_health", 96'(health0), 96'(12'h0C0));
    drive(32'h55, 32'h54, 32'h55);
    tick();
    check("recmis_broken", 96'(broken0), 96'(3'b010));
    drive(32'h55, 32'h55, 32'h55);
    repeat (63) tick();
    check("rec2_63_broken", 96'(broken0), 96'(3'b010));
    tick();
    check("rec2_64_broken", 96'(broken0), 96'(3'b000));
    check("rec2_health", 96'(health0), 96'(12'h000));

    // Force-retire all
    set_broken = 3'b111;
    tick();
    set_broken = 3'b000;
    check("force_broken", 96'(broken0), 96'(3'b111));
    check("force_allb", 96'(allb0), 96'(1'b1));
    drive(32'hA, 32'hB, 32'hC);
    @(negedge clk);
    check("allb_vote", voted0, {3{32'hA}});
    check("allb_err", 96'({det0, corr0}), 96'(2'b00));
    drive(32'hA, 32'hA, 32'hA);
    repeat (200) tick();
    check("norec_broken", 96'(broken0), 96'(3'b111));
    check("norec_allb", 96'(allb0), 96'(1'b1));

    // One-cycle reset clears everything; majority governs during reset
    drive(32'hA, 32'hB, 32'hC);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_vote", voted0, {3{32'hA}});
    check("rst2_err", 96'({det0, corr0}), 96'(2'b11));
    tick();
    rst_n = 1'b1;
    check("rst2_broken", 96'(broken0), 96'(3'b000));
    check("rst2_allb", 96'(allb0), 96'(1'b0));
    check("rst2_health", 96'(health0), 96'(12'h000));

    // Independent output voters with lane 1 stuck at zero
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      v = 32'h01010101 * 32'(i + 1);
      drive(v, 32'h0, v);
      @(negedge clk);
      check("tout_vote", voted1, {3{v}});
      check("tout_det", 96'(det1), (i < 3) ? 96'(1'b1) : 96'(1'b0));
      tick();
    end
    check("tout_broken", 96'(broken1), 96'(3'b010));
    check("tout_health", 96'(health1), 96'(12'h0C0));
    check("tout_corr", 96'(corr1), 96'(1'b0));
    check("tout_allb", 96'(allb1), 96'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
